// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types for the main-memory refill arbiter: FSM states, transfer owner
// encoding and the byte-to-word shift used when stepping through a line.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_BURST = 2'd1,
      D_BURST = 2'd2,
      DONE    = 2'd3
   } arbState_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/mem_refill_arbiter_beat_counter.sv
// Word counter for one line burst: cleared at grant, advanced on each memory
// ack, and flags the final word of the line.
module refill_beat_counter #(
   parameter int LINE_WORDS = 8,
   localparam int IDX_W     = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             incr,
   output logic [IDX_W-1:0] idx,
   output logic             isLast
);

   // Clear wins over increment so a new grant always starts at word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (incr) begin
         idx <= idx + 1'b1;
      end
   end

   assign isLast = (idx == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_refill_arbiter.sv
// Arbitrates the single main-memory port between I-cache and D-cache line
// transfers, sequencing each line as a word-by-word burst against mem_ack.
module mem_refill_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ic_req,
   input  logic [ADDR_W-1:0]             ic_addr,
   output logic                          ic_gnt,
   output logic                          ic_rvalid,
   output logic [DATA_W-1:0]             ic_rdata,
   output logic                          ic_done,
   input  logic                          dc_req,
   input  logic                          dc_we,
   input  logic [ADDR_W-1:0]             dc_addr,
   input  logic [DATA_W-1:0]             dc_wdata,
   output logic                          dc_gnt,
   output logic                          dc_rvalid,
   output logic [DATA_W-1:0]             dc_rdata,
   output logic                          dc_done,
   output logic                          dc_wready,
   output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ack,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int IDX_W    = $clog2(LINE_WORDS);
   localparam int OFF_BITS = IDX_W + WORD_SHIFT;
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_BITS;

   arbState_t         state;
   owner_t            owner;
   logic [ADDR_W-1:0] baseAddr;
   logic              writeFlag;

   logic inBurst;
   logic inIBurst;
   logic inDBurst;
   logic beatAck;
   logic startGrant;
   logic lastBeat;
   logic readBeat;

   assign inIBurst   = (state == I_BURST);
   assign inDBurst   = (state == D_BURST);
   assign inBurst    = inIBurst || inDBurst;
   assign beatAck    = inBurst && mem_ack;
   assign startGrant = (state == IDLE) && (dc_req || ic_req);

   refill_beat_counter #(
      .LINE_WORDS (LINE_WORDS)
   ) beatCounter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (startGrant),
      .incr   (beatAck),
      .idx    (beat_idx),
      .isLast (lastBeat)
   );

   // Arbitration and burst sequencing. D wins ties because a D miss always
   // belongs to the older instruction in the pipeline. Requests are only
   // looked at in IDLE, so a dropped req cannot abort a burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_I;
         baseAddr  <= '0;
         writeFlag <= 1'b0;
         ic_gnt    <= 1'b0;
         dc_gnt    <= 1'b0;
      end else begin
         ic_gnt <= 1'b0;
         dc_gnt <= 1'b0;
         case (state)
            IDLE: begin
               if (dc_req) begin
                  state     <= D_BURST;
                  owner     <= OWN_D;
                  baseAddr  <= dc_addr & LINE_MASK;
                  writeFlag <= dc_we;
                  dc_gnt    <= 1'b1;
               end else if (ic_req) begin
                  state     <= I_BURST;
                  owner     <= OWN_I;
                  baseAddr  <= ic_addr & LINE_MASK;
                  writeFlag <= 1'b0;
                  ic_gnt    <= 1'b1;
               end
            end
            I_BURST, D_BURST: begin
               if (mem_ack && lastBeat) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Memory side depends only on state and latched burst context, so it holds
   // steady across wait states; the address wraps modulo 2^ADDR_W.
   assign mem_req   = inBurst;
   assign mem_we    = inBurst && writeFlag;
   assign mem_addr  = inBurst ? (baseAddr + (ADDR_W'(beat_idx) << WORD_SHIFT)) : '0;
   assign mem_wdata = (inDBurst && writeFlag) ? dc_wdata : '0;

   assign readBeat  = beatAck && !writeFlag;
   assign ic_rvalid = readBeat && inIBurst;
   assign dc_rvalid = readBeat && inDBurst;
   assign ic_rdata  = inIBurst ? mem_rdata : '0;
   assign dc_rdata  = (inDBurst && !writeFlag) ? mem_rdata : '0;
   assign dc_wready = beatAck && inDBurst && writeFlag;

   assign ic_done = (state == DONE) && (owner == OWN_I);
   assign dc_done = (state == DONE) && (owner == OWN_D);

endmodule
